// File: rtl/tx_pkg.sv
// Shared definitions for the transmit test-payload source: mode codes, FSM states, PN taps.
// Latency: none (package only).
// Backpressure: not applicable.
package tx_pkg;

    localparam logic [3:0] MODE_BPSK = 4'b0001;
    localparam logic [3:0] MODE_QPSK = 4'b0010;
    localparam logic [3:0] MODE_MIX  = 4'b0100;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STREAM_B  = 3'd1,
        STREAM_Q  = 3'd2,
        BURST     = 3'd3,
        WAIT_SENT = 3'd4
    } tx_state_t;

    // Middle tap K of the trinomial x^N + x^K + 1 for each supported order.
    localparam int PN5_TAP = 3;
    localparam int PN4_TAP = 3;

    // Returns the middle tap for an LFSR order, or 0 when the order is unsupported.
    function automatic int pn_tap(input int order);
        int tap;
        tap = 0;
        case (order)
            5:       tap = PN5_TAP;
            4:       tap = PN4_TAP;
            default: tap = 0;
        endcase
        return tap;
    endfunction

endpackage

// File: rtl/pn_lfsr.sv
// Fibonacci PN generator, seeded all-ones, advancing one bit per step pulse.
// Latency: pn is the current MSB; it moves to the next sequence bit the cycle after step.
// Backpressure: the generator only moves when step is high, so stalls never skip a bit.
module pn_lfsr
    import tx_pkg::*;
#(
    parameter int N = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic step,
    output logic pn
);

    localparam int TAP   = pn_tap(N);
    localparam int TAP_I = (TAP > 0) ? TAP - 1 : 0;

    generate
        if (TAP == 0) begin : g_bad_order
            $error("pn_lfsr: unsupported LFSR order");
        end
    endgenerate

    logic [N-1:0] sr_q;
    logic [N-1:0] sr_d;

    // Shift left, feeding back the XOR of the two trinomial taps into bit 0.
    always_comb begin
        sr_d = sr_q;
        if (step) begin
            sr_d = {sr_q[N-2:0], sr_q[N-1] ^ sr_q[TAP_I]};
        end
    end

    // Shift register state, all-ones seed on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '1;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign pn = sr_q[N-1];

endmodule

// File: rtl/tx_data_gen.sv
// Test-payload source (BPSK/QPSK streams or packetised mixed mode) feeding the Packetizer.
// Latency: first beat valid 1 cycle after leaving IDLE/WAIT_SENT; all outputs registered.
// Backpressure: output register reloads only when !tvalid || tready; a held beat stays stable.
// Optional feature: define TX_DATA_GEN_SEQ_EN for an incrementing-counter payload instead of PN.
module tx_data_gen
    import tx_pkg::*;
#(
    parameter int BYTES      = 1,
    parameter int LEN_W      = 16,
    parameter int PN_ORDER_I = 5,
    parameter int PN_ORDER_Q = 4,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           MODE_CTRL,
    input  logic [LEN_W-1:0]     payload_len_cfg,
    input  logic                 pkt_sent,
    output logic [BYTES*8-1:0]   data_tdata,
    output logic                 data_tvalid,
    input  logic                 data_tready,
    output logic                 data_tlast,
    output logic                 data_tuser,
    output logic [LEN_W-1:0]     payload_length,
    output logic [CNT_W-1:0]     pkt_count
);

    localparam int BITS = BYTES * 8;

    tx_state_t        state_q, state_d;
    logic [BITS-1:0]  tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d;
    logic             tlast_q, tlast_d;
    logic             tuser_q, tuser_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic             mix_bpsk_q, mix_bpsk_d;

    logic             load_en;
    logic             load_beat;
    logic             load_bpsk;
    logic             load_last;
    logic             step;
    logic [BITS-1:0]  bpsk_dat;
    logic [BITS-1:0]  qpsk_dat;
    logic             mix_arm;

    assign load_en = !tvalid_q || data_tready;
    assign mix_arm = (MODE_CTRL == MODE_MIX) && (payload_len_cfg != '0);

`ifdef TX_DATA_GEN_SEQ_EN
    logic [BITS-1:0] seq_q, seq_d;

    // Counting payload: one increment per loaded beat, wrapping naturally.
    always_comb begin
        seq_d    = step ? seq_q + BITS'(1) : seq_q;
        bpsk_dat = seq_q;
        qpsk_dat = seq_q;
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_q <= '0;
        end else begin
            seq_q <= seq_d;
        end
    end
`else
    logic pn_i;
    logic pn_q;

    pn_lfsr #(.N(PN_ORDER_I)) u_pn_i (
        .clk  (clk),
        .rst  (rst),
        .step (step),
        .pn   (pn_i)
    );

    pn_lfsr #(.N(PN_ORDER_Q)) u_pn_q (
        .clk  (clk),
        .rst  (rst),
        .step (step),
        .pn   (pn_q)
    );

    // Symbol formatting: BPSK replicates I, QPSK puts Q in the LSB.
    always_comb begin
        bpsk_dat = {BITS{pn_i}};
        qpsk_dat = {{(BITS-1){pn_i}}, pn_q};
    end
`endif

    // Next-state and output-register logic; a beat is loaded only on a load opportunity.
    always_comb begin
        state_d    = state_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        tuser_d    = tuser_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        mix_bpsk_d = mix_bpsk_q;
        load_beat  = 1'b0;
        load_bpsk  = 1'b0;
        load_last  = 1'b0;
        step       = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_en) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                end
                if (MODE_CTRL == MODE_BPSK) begin
                    state_d = STREAM_B;
                end else if (MODE_CTRL == MODE_QPSK) begin
                    state_d = STREAM_Q;
                end else if (mix_arm) begin
                    len_d      = payload_len_cfg;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end

            STREAM_B, STREAM_Q: begin
                if (load_en) begin
                    if ((state_q == STREAM_B && MODE_CTRL == MODE_BPSK) ||
                        (state_q == STREAM_Q && MODE_CTRL == MODE_QPSK)) begin
                        load_beat = 1'b1;
                        load_bpsk = (state_q == STREAM_B);
                    end else begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end

            BURST: begin
                if (load_en) begin
                    if (tvalid_q && tlast_q) begin
                        // Last beat of the packet has just been accepted.
                        tvalid_d  = 1'b0;
                        tlast_d   = 1'b0;
                        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                        state_d   = WAIT_SENT;
                    end else begin
                        load_beat  = 1'b1;
                        load_bpsk  = mix_bpsk_q;
                        load_last  = (beat_cnt_q == len_q - LEN_W'(1));
                        beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    end
                end
            end

            WAIT_SENT: begin
                if (pkt_sent) begin
                    mix_bpsk_d = !mix_bpsk_q;
                    if (mix_arm) begin
                        len_d      = payload_len_cfg;
                        beat_cnt_d = '0;
                        state_d    = BURST;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d  = IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase

        if (load_beat) begin
            step     = 1'b1;
            tvalid_d = 1'b1;
            tlast_d  = load_last;
            tuser_d  = load_bpsk;
            tdata_d  = load_bpsk ? bpsk_dat : qpsk_dat;
        end
    end

    // State and output registers; reset aborts any packet without a tlast.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tuser_q    <= 1'b0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            mix_bpsk_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tuser_q    <= tuser_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            mix_bpsk_q <= mix_bpsk_d;
        end
    end

    assign data_tdata     = tdata_q;
    assign data_tvalid    = tvalid_q;
    assign data_tlast     = tlast_q;
    assign data_tuser     = tuser_q;
    assign payload_length = len_q;
    assign pkt_count      = pkt_cnt_q;

endmodule

// File: doc/tx_data_gen.md
Name: tx_data_gen

Overview:
- Parametrised test-payload source for the PSK transmit chain, sitting upstream of the Packetizer on an AXI-Stream link.
- Generates PN-sequence symbols in continuous BPSK, continuous QPSK, or packetised mixed mode.
- Fully honours tready back-pressure.
- Adds a run-time payload length, per-packet BPSK/QPSK alternation in mixed mode, and a packet counter.

Parameters:
- BYTES, 1: tdata width in bytes (≥1); BITS = BYTES*8.
- LEN_W, 16: width of the payload length and beat counter.
- PN_ORDER_I, 5: order of the in-phase PN LFSR.
- PN_ORDER_Q, 4: order of the quadrature PN LFSR.
- CNT_W, 16: width of the packet counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- MODE_CTRL  in  4  4'b0001 BPSK stream, 4'b0010 QPSK stream, 4'b0100 mixed packets; any other value means idle
- payload_len_cfg  in  LEN_W  beats per packet in mixed mode
- pkt_sent  in  1  single-cycle pulse from the Packetizer when the previous packet has left
- data_tdata  out  BITS  symbol bits
- data_tvalid  out  1  AXIS valid
- data_tready  in  1  AXIS ready
- data_tlast  out  1  last beat of packet
- data_tuser  out  1  1 means the beat is BPSK
- payload_length  out  LEN_W  length latched for the current packet
- pkt_count  out  CNT_W  number of completed packets (tlast handshakes)

Behaviour:
- Reset values (asynchronous):
  - tdata=0, tvalid=0, tlast=0, tuser=0, payload_length=0, pkt_count=0.
  - State is IDLE, mix_is_bpsk=1.
  - Both LFSRs are seeded all-ones.
- LFSR polynomials: order 5 uses x^5+x^3+1; order 4 uses x^4+x^3+1. Unsupported orders are a parameter error.
- Output register:
  - The register loads new data only when !tvalid || tready.
  - While tvalid=1 && tready=0, tdata, tlast and tuser hold stable.
- LFSR stepping: the LFSRs advance only when a new beat is loaded, so no PN bit is skipped under back-pressure.
- Symbol formatting:
  - BPSK beat: tdata = {BITS{pn_i}}.
  - QPSK beat: tdata = {{BITS-1{pn_i}}, pn_q}.
- States:
  - IDLE: tvalid deasserts at the next load opportunity.
    - MODE_CTRL=BPSK goes to STREAM_B.
    - MODE_CTRL=QPSK goes to STREAM_Q.
    - MODE_CTRL=MIX with payload_len_cfg≠0 latches the length into payload_length, clears the beat counter, and goes to BURST.
  - STREAM_B / STREAM_Q: continuous tvalid=1, tlast=0, tuser=1 or 0 respectively.
    - A change of MODE_CTRL returns to IDLE at the next load opportunity; any current beat completes its handshake first.
  - BURST: each accepted beat increments the beat counter.
    - The beat with counter = payload_length-1 carries tlast=1.
    - tuser=mix_is_bpsk for every beat of the packet.
    - The tlast handshake increments pkt_count (wraps at 2^CNT_W) and goes to WAIT_SENT.
  - WAIT_SENT: tvalid=0.
    - On pkt_sent: toggle mix_is_bpsk; if MODE_CTRL is still MIX and payload_len_cfg≠0, latch the new length and go to BURST, else go to IDLE.
- pkt_sent outside WAIT_SENT is ignored.
- MODE_CTRL and payload_len_cfg changes during BURST take effect only at the packet boundary; a packet is never truncated.
- payload_len_cfg=1 produces single-beat packets with tlast on every beat.
- payload_len_cfg=0 in MIX keeps the block in IDLE.
- Latency: the first tvalid appears 1 cycle after the state leaves IDLE/WAIT_SENT.
- Reset asserted mid-packet aborts immediately: outputs return to reset values with no tlast emitted.

Optional Feature:
- Macro: TX_DATA_GEN_SEQ_EN.
- When defined: tdata is an incrementing BITS-wide counter instead of PN. The counter starts at 0 after reset, steps on every loaded beat, and wraps modulo 2^BITS. tuser, tlast and framing are unchanged.
- When undefined: PN payload as above, and no counter logic is synthesised.

Decomposition:
- Shared package tx_pkg:
  - mode localparams MODE_BPSK/MODE_QPSK/MODE_MIX;
  - state enum {IDLE, STREAM_B, STREAM_Q, BURST, WAIT_SENT};
  - LFSR tap constants per order.
- One sub-module, pn_lfsr (parameter N, ports clk, rst, step, pn), instantiated twice.

Test Plan:
- BPSK stream, tready tied 1 → tvalid high continuously, tuser=1, tlast=0, tdata[0] matches the order-5 golden sequence starting 1,1,1,1,1,0.
- QPSK stream, tready toggled 1-0-0-1 → tdata held during stalls; the per-beat {pn_i,pn_q} sequence has no gaps or repeats versus the golden model.
- MIX mode, len=4, pkt_sent pulsed 3 cycles after each tlast → packets of exactly 4 beats, tuser pattern 1,0,1 across packets, pkt_count=3.
- MIX mode, len changed 4→2 mid-packet → the current packet still has 4 beats and the next has 2.
- MIX mode with len=0, and pkt_sent pulsed while in BURST → no output or no effect respectively; the FSM does not advance.
- rst asserted on beat 2 of a 4-beat packet → all outputs 0 the same cycle; after release and pkt re-arm, the LFSR restarts from the all-ones seed.
